wb_sram_bist_master: RTL

WB_SRAM_BIST_MASTER -- requirements
Module: wb_sram_bist_master

---
 rtl/wb_sram_pkg.sv | 18 +
 rtl/wb_xfer_ctrl.sv | 35 +++
 rtl/wb_sram_bist_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared types and constants for the Wishbone SRAM BIST master.
package wb_sram_pkg;
    localparam int WB_DW = 32;
    localparam int WB_AW = 32;
    localparam logic [3:0] SEL_ALL = 4'hF;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE, ABORT} bist_state_e;

    function automatic logic [WB_DW-1:0] pattern(
        input logic [WB_DW-1:0] seed,
        input logic [WB_AW-1:0] idx,
        input logic             inv
    );
        return (seed ^ idx) ^ {WB_DW{inv}};
    endfunction
endpackage

// File: rtl/wb_xfer_ctrl.sv
// wb_xfer_ctrl: one Wishbone classic transfer (cyc/stb hold until ack) with a stb-to-ack timeout.
module wb_xfer_ctrl import wb_sram_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic go_i,
    input  logic ack_i,
    output logic stb_o,
    output logic ack_o,
    output logic timeout_o
);
    logic       stb_q, stb_d;
    logic [7:0] tmr_q, tmr_d;

    assign stb_o     = stb_q;
    assign ack_o     = stb_q && ack_i;
    // Fires on the TIMEOUT-th stb cycle so stb is dropped on the following one.
    assign timeout_o = stb_q && !ack_i && (tmr_q == 8'(TIMEOUT - 1));

    always_comb begin
        stb_d = go_i ? 1'b1 : (ack_o || timeout_o) ? 1'b0 : stb_q;
        tmr_d = go_i ? 8'd0 : stb_q ? tmr_q + 8'd1 : tmr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_q <= 1'b0;
            tmr_q <= 8'd0;
        end else begin
            stb_q <= stb_d;
            tmr_q <= tmr_d;
        end
    end
endmodule

// File: rtl/wb_sram_bist_master.sv
// wb_sram_bist_master: Wishbone initiator running a write/read/compare BIST over an SRAM window.
module wb_sram_bist_master import wb_sram_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [31:0] base_adr_i,
    input  logic [31:0] seed_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] fail_adr_o
);
    localparam int IW = $clog2(DEPTH);

    bist_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WB_AW-1:0] base_q, base_d, fail_adr_q, fail_adr_d, adr;
    logic [WB_DW-1:0] seed_q, seed_d, exp_dat;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic [1:0]       rst_sync_q;
    logic             rst_n, go, stb, ack, tmo, accept, phase, rd, we, mis;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) rst_sync_q <= 2'b00;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign accept  = (state_q == IDLE) && start_i;
    assign phase   = state_q inside {W0, R0, W1, R1};
    assign rd      = state_q inside {R0, R1};
    assign we      = state_q inside {W0, W1};
    assign go      = accept || (phase && !stb);
    assign adr     = base_q + (WB_AW'(idx_q) << 2);
    assign exp_dat = pattern(seed_q, WB_AW'(idx_q), state_q inside {W1, R1});
    assign mis     = ack && rd && (wbm_dat_i != exp_dat);

    wb_xfer_ctrl #(.TIMEOUT(TIMEOUT)) u_xfer (
        .clk_i     (wb_clk_i),
        .rst_ni    (rst_n),
        .go_i      (go),
        .ack_i     (wbm_ack_i),
        .stb_o     (stb),
        .ack_o     (ack),
        .timeout_o (tmo)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (accept) begin
            state_d = W0;
            idx_d   = '0;
        end else if (phase && tmo) begin
            state_d = ABORT;
        end else if (phase && ack) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DEPTH - 1)) state_d = bist_state_e'(state_q + 3'd1);
        end else if (state_q inside {DONE, ABORT}) begin
            state_d = IDLE;
        end
    end

    // The error count never returns to zero within a test, so zero marks "no mismatch yet".
    always_comb begin
        base_d     = accept ? base_adr_i : base_q;
        seed_d     = accept ? seed_i : seed_q;
        err_cnt_d  = accept ? 16'd0 : (mis && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        fail_adr_d = accept ? '0 : (mis && err_cnt_q == 16'd0) ? adr : fail_adr_q;
        timeout_d  = accept ? 1'b0 : tmo ? 1'b1 : timeout_q;
        done_d     = state_q inside {DONE, ABORT};
        pass_d     = accept ? 1'b0 : done_d ? (err_cnt_q == 16'd0 && !timeout_q) : pass_q;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            err_cnt_q  <= '0;
            fail_adr_q <= '0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            seed_q     <= seed_d;
            err_cnt_q  <= err_cnt_d;
            fail_adr_q <= fail_adr_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign wbm_cyc_o  = stb;
    assign wbm_stb_o  = stb;
    assign wbm_we_o   = stb && we;
    assign wbm_sel_o  = stb ? SEL_ALL : 4'h0;
    assign wbm_adr_o  = stb ? adr : '0;
    assign wbm_dat_o  = (stb && we) ? exp_dat : '0;
    assign busy_o     = state_q != IDLE;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign timeout_o  = timeout_q;
    assign err_cnt_o  = err_cnt_q;
    assign fail_adr_o = fail_adr_q;
endmodule
